// File: rtl/rctx_tx_sequencer.sv
// Control sequencer for the PRBS -> raised-cosine TX path. It generates the symbol/shift strobes, the polyphase index and the valid qualifier.
// Latency: every output decodes registered state. i_sw is sampled in IDLE and at RUN symbol boundaries, and takes effect on the next cycle.
// Backpressure: none. FILL and DRAIN always run OS*N_BAUDS cycles, and a RUN symbol is never truncated.
module rctx_tx_sequencer #(
  parameter int OS        = 4,
  parameter int N_BAUDS   = 6,
  parameter int NB_PHASE  = 2,
  parameter int NB_SYMCNT = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_sw,
  output logic [NB_PHASE-1:0]  o_phase,
  output logic                 o_sym_tick,
  output logic                 o_shift_en,
  output logic                 o_zero_sym,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic [1:0]           o_state,
  output logic [NB_SYMCNT-1:0] o_sym_count
);

  localparam int NB_SC = (N_BAUDS > 1) ? $clog2(N_BAUDS) : 1;
  localparam logic [NB_PHASE-1:0] PH_LAST = NB_PHASE'(OS - 1);
  localparam logic [NB_SC-1:0]    SC_LAST = NB_SC'(N_BAUDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NB_PHASE-1:0]    phase_q, phase_d;
  logic [NB_SC-1:0]       sc_q, sc_d;
  logic [NB_SYMCNT-1:0]   sym_count_q, sym_count_d;
  logic                   boundary;
  logic                   sym_tick;

  assign boundary = (phase_q == PH_LAST);
  assign sym_tick = ((state_q == ST_FILL) || (state_q == ST_RUN)) && (phase_q == '0);

  // Next state, phase and fill/drain symbol count. The phase wraps explicitly at OS-1.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sc_d        = sc_q;
    sym_count_d = sym_count_q + NB_SYMCNT'(sym_tick);

    if (state_q != ST_IDLE) begin
      phase_d = boundary ? '0 : phase_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (i_sw) begin
          state_d = ST_FILL;
          sc_d    = '0;
        end
      end
      ST_FILL: begin
        if (boundary) begin
          if (sc_q == SC_LAST) begin
            state_d = ST_RUN;
            sc_d    = '0;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        // The stop request only counts on a symbol boundary, so a symbol is never cut short.
        if (boundary && !i_sw) begin
          state_d = ST_DRAIN;
          sc_d    = '0;
        end
      end
      ST_DRAIN: begin
        if (boundary) begin
          if (sc_q == SC_LAST) begin
            state_d = ST_IDLE;
            sc_d    = '0;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. A reset aborts immediately, even in the middle of a drain.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      sc_q        <= '0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sc_q        <= sc_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign o_phase     = phase_q;
  assign o_sym_tick  = sym_tick;
  assign o_shift_en  = (state_q != ST_IDLE) && (phase_q == '0);
  assign o_zero_sym  = (state_q == ST_DRAIN);
  assign o_valid     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_state     = state_q;
  assign o_sym_count = sym_count_q;

endmodule

// File: tb/tb_rctx_tx_sequencer.sv
// Directed bench for rctx_tx_sequencer (OS=4, N_BAUDS=6).
// A second instance with a 4-bit symbol counter exercises the wrap.
module tb_rctx_tx_sequencer;

  logic        clock;
  logic        i_reset;
  logic        i_sw;
  logic [1:0]  o_phase, o_phase4;
  logic        o_sym_tick, o_shift_en, o_zero_sym, o_valid, o_busy;
  logic        o_sym_tick4, o_shift_en4, o_zero_sym4, o_valid4, o_busy4;
  logic [1:0]  o_state, o_state4;
  logic [15:0] o_sym_count;
  logic [3:0]  o_sym_count4;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 0;

  rctx_tx_sequencer #(.OS(4), .N_BAUDS(6), .NB_PHASE(2), .NB_SYMCNT(16)) u_dut (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw),
    .o_phase(o_phase), .o_sym_tick(o_sym_tick), .o_shift_en(o_shift_en),
    .o_zero_sym(o_zero_sym), .o_valid(o_valid), .o_busy(o_busy),
    .o_state(o_state), .o_sym_count(o_sym_count)
  );

  rctx_tx_sequencer #(.OS(4), .N_BAUDS(6), .NB_PHASE(2), .NB_SYMCNT(4)) u_dut4 (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw),
    .o_phase(o_phase4), .o_sym_tick(o_sym_tick4), .o_shift_en(o_shift_en4),
    .o_zero_sym(o_zero_sym4), .o_valid(o_valid4), .o_busy(o_busy4),
    .o_state(o_state4), .o_sym_count(o_sym_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and check every output against the expected state and phase.
  task automatic step_chk(input string tag, input int st, input int ph);
    logic tick, shift;
    @(posedge clock);
    #1;
    tick  = ((st == 1) || (st == 2)) && (ph == 0);
    shift = (st != 0) && (ph == 0);
    chk({tag, "_state"},  32'(o_state),      32'(st));
    chk({tag, "_phase"},  32'(o_phase),      32'(ph));
    chk({tag, "_tick"},   32'(o_sym_tick),   32'(tick));
    chk({tag, "_shift"},  32'(o_shift_en),   32'(shift));
    chk({tag, "_zero"},   32'(o_zero_sym),   32'(st == 3));
    chk({tag, "_valid"},  32'(o_valid),      32'(st >= 2));
    chk({tag, "_busy"},   32'(o_busy),       32'(st != 0));
    chk({tag, "_cnt"},    32'(o_sym_count),  exp_cnt & 32'hFFFF);
    chk({tag, "_cnt4"},   32'(o_sym_count4), exp_cnt & 32'hF);
    chk({tag, "_state4"}, 32'(o_state4),     32'(st));
    if (tick) exp_cnt = exp_cnt + 1;
  endtask

  initial begin
    // Reset is held with the run request already high.
    i_reset = 1'b1;
    i_sw    = 1'b1;
    for (int i = 0; i < 10; i++) step_chk("rst_hold", 0, 0);

    // Start-up: FILL for 24 cycles, then RUN.
    i_reset = 1'b0;
    for (int i = 0; i < 24; i++) step_chk("fill_a", 1, i % 4);
    step_chk("run_a", 2, 0);
    chk("cnt_at_run", 32'(o_sym_count), 32'd6);
    step_chk("run_a", 2, 1);
    step_chk("run_a", 2, 2);
    i_sw = 1'b0;                       // glitch low between boundaries
    step_chk("glitch", 2, 3);
    i_sw = 1'b1;
    step_chk("glitch_run", 2, 0);
    step_chk("run_a", 2, 1);
    i_sw = 1'b0;                       // stop requested at phase 1
    step_chk("stop_run", 2, 2);
    step_chk("stop_run", 2, 3);
    for (int i = 0; i < 24; i++) step_chk("drain_a", 3, i % 4);
    step_chk("idle_a", 0, 0);
    chk("cnt_frozen", 32'(o_sym_count), 32'd8);
    step_chk("idle_a", 0, 0);

    // Restart with i_sw held high through the whole drain.
    i_sw = 1'b1;
    for (int i = 0; i < 24; i++) step_chk("fill_b", 1, i % 4);
    step_chk("run_b", 2, 0);
    step_chk("run_b", 2, 1);
    step_chk("run_b", 2, 2);
    step_chk("run_b", 2, 3);
    i_sw = 1'b0;                       // low exactly on the boundary cycle
    step_chk("drain_b", 3, 0);
    i_sw = 1'b1;
    for (int i = 1; i < 24; i++) step_chk("drain_b", 3, i % 4);
    step_chk("idle_b", 0, 0);
    step_chk("refill", 1, 0);

    // Short stop: request dropped right after FILL entry.
    i_sw = 1'b0;
    for (int i = 1; i < 24; i++) step_chk("fill_c", 1, i % 4);
    for (int i = 0; i < 4; i++)  step_chk("run_c", 2, i);
    for (int i = 0; i < 24; i++) step_chk("drain_c", 3, i % 4);
    step_chk("idle_c", 0, 0);
    chk("cnt_short", 32'(o_sym_count), 32'd22);
    step_chk("idle_c", 0, 0);

    // Reset while in DRAIN at phase 2.
    i_sw = 1'b1;
    for (int i = 0; i < 24; i++) step_chk("fill_d", 1, i % 4);
    step_chk("run_d", 2, 0);
    i_sw = 1'b0;
    for (int i = 1; i < 4; i++) step_chk("run_d", 2, i);
    step_chk("drain_d", 3, 0);
    step_chk("drain_d", 3, 1);
    step_chk("drain_d", 3, 2);
    i_reset = 1'b1;
    exp_cnt = 0;
    step_chk("rst_mid", 0, 0);
    i_reset = 1'b0;
    step_chk("post_rst", 0, 0);

    // Counter wrap: 17 ticks leave the 4-bit counter at 1.
    i_sw = 1'b1;
    for (int i = 0; i < 24; i++) step_chk("fill_e", 1, i % 4);
    for (int i = 0; i < 44; i++) step_chk("run_e", 2, i % 4);
    chk("wrap_cnt4", 32'(o_sym_count4), 32'd1);
    chk("wrap_cnt16", 32'(o_sym_count), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
